gray_counter_param: RTL and testbench
=====================================

Name: gray_counter_param

Overview:
Parametrised Gray-code counter. It generalises the fixed 3-bit up-counter to WIDTH bits and adds up/down counting, synchronous load, wrap or saturate mode, and separate sticky over/underflow flags. It is used as a standalone counter and as the pointer generator for future clock-crossing FIFOs, so its Gray output is registered and glitch-free.

Parameters:
WIDTH, 3, counter width in bits; legal range 2..16.
WRAP, 1, 1 = wrap at the boundaries; 0 = saturate (hold) at the boundaries.
STICKY, 1, 1 = flags hold until ClrFlags or Reset; 0 = flags are single-cycle pulses.

Ports:
Clk  input  1  single clock; all state updates on its rising edge.
Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
En  input  1  count enable.
Up  input  1  direction: 1 = increment, 0 = decrement.
Load  input  1  synchronous load strobe.
LoadVal  input  WIDTH  value to load, in Gray code.
ClrFlags  input  1  synchronous clear of Overflow and Underflow (used when STICKY=1).
Output  output  WIDTH  current count, Gray code, registered.
Binary  output  WIDTH  current count, binary, registered.
Overflow  output  1  an up-count was attempted from the maximum value.
Underflow  output  1  a down-count was attempted from zero.

Behaviour:
- Reset low (asynchronous):
  - Binary=0, Output=0, Overflow=0, Underflow=0 immediately.
  - Reset release takes effect at the next Clk edge with no extra delay.
- State is a binary register bcnt. Output is a separate register loaded with bin2gray(next bcnt). Output and Binary therefore change on the same edge, and Output is always bin2gray(Binary).
- Latency: 1 cycle. A control input sampled at edge N is reflected on the outputs immediately after edge N.
- Priority per edge: Load > En. En=0 and Load=0 means hold.
- Load=1:
  - bcnt <= gray2bin(LoadVal).
  - Overflow/Underflow are not set by a load.
  - A load ignores En and Up.
- En=1, Up=1:
  - bcnt != MAX (2^WIDTH-1): bcnt+1.
  - bcnt == MAX: WRAP=1 gives 0; WRAP=0 holds MAX. Overflow is set in both modes.
- En=1, Up=0:
  - bcnt != 0: bcnt-1.
  - bcnt == 0: WRAP=1 gives MAX; WRAP=0 holds 0. Underflow is set in both modes.
- Flags, STICKY=1:
  - A flag stays 1 until ClrFlags=1 or Reset.
  - ClrFlags together with a new event on the same edge: the flag ends at 1 (set wins).
  - ClrFlags alone: the flag is 0 after the edge.
- Flags, STICKY=0:
  - A flag is 1 for exactly the cycle following the event edge, then 0.
  - ClrFlags has no effect.
- Overflow and Underflow can never both be set by a single edge. Both can be 1 together in sticky mode after separate events.
- Arithmetic is modulo 2^WIDTH inside WIDTH bits. There is no carry-out port; the flags replace it.
- Direction change mid-count (Up toggles while En=1) takes effect on the next edge with no bubble.
- Reset asserted mid-count or mid-load aborts the operation; all outputs go to 0.
- Gray property: when WRAP=1 and Load=0, consecutive Output values differ in exactly one bit, including at the wrap.

Decomposition:
- Shared package gray_pkg:
  - functions bin2gray(b) = b ^ (b>>1), and gray2bin (prefix XOR from MSB), both width-generic;
  - constant GRAY_MAX_WIDTH = 16.
- One sub-module: gray_conv (combinational, parameter WIDTH, ports Bin -> Gray and Gray -> Bin). It is instantiated once for the LoadVal decode and once for the next-Output encode.
- The counter control logic stays in gray_counter_param.

Test Plan:
1. Basic count and wrap (WIDTH=3, WRAP=1, STICKY=1):
   - Stimulus: Reset low then high, En=1, Up=1 for 9 edges.
   - Required: Output = 000,001,011,010,110,111,101,100,000. Overflow becomes 1 after the 8th edge and stays 1. Every step changes exactly one bit.
2. Down and underflow (WIDTH=3, WRAP=1):
   - Stimulus: from 0, Up=0, En=1 for 1 edge.
   - Required: Binary=7, Output=100, Underflow=1. Next edge: Binary=6, Output=101.
3. Saturate (WRAP=0, WIDTH=4):
   - Stimulus: Load LoadVal=1000 (binary 15), then En=1, Up=1 for 3 edges.
   - Required: Binary holds 15, Output=1000, Overflow=1. Then Up=0: Binary=14, Output=1001.
4. Flag clear race (STICKY=1):
   - Stimulus: at MAX, assert En=1, Up=1, ClrFlags=1 on the same edge.
   - Required: Overflow=1.
   - Next edge with ClrFlags=1, En=0: Overflow=0.
   - With STICKY=0, an identical wrap gives Overflow high for exactly 1 cycle.
5. Load priority:
   - Stimulus: Load=1, En=1, Up=1, LoadVal=110 (WIDTH=3).
   - Required: after the edge Binary=4, Output=110 (no increment), no flag set.
6. Async reset mid-count:
   - Stimulus: count to Binary=5, drive Reset low between clock edges.
   - Required: all outputs 0 before the next Clk edge.
   - After release with En=1, Up=1: the first edge gives Output=001.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and limits for the Gray counter family.
// The conversion functions work at the maximum width; narrower callers zero-extend.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 16;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] b
    );
        return b ^ (b >> 1'b1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the low bits correct.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] g
    );
        logic [GRAY_MAX_WIDTH-1:0] b;
        b = {GRAY_MAX_WIDTH{1'b0}};
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 32'sd0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational WIDTH-bit converter: one binary-to-Gray path and one Gray-to-binary path.
// Paths are independent so an instance can serve either direction.
module gray_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o,
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    assign gray_o = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_i)));
    assign bin_o  = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(gray_i)));

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with load, wrap/saturate and over/underflow flags.
// The Gray output is its own register fed from the encoded next count, so it never glitches.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter bit WRAP   = 1'b1,
    parameter bit STICKY = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bcnt_q, bcnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_evt_s, unf_evt_s;
    logic [WIDTH-1:0] load_bin_s;
    logic [WIDTH-1:0] unused_gray_s;
    logic [WIDTH-1:0] unused_bin_s;

    gray_conv #(.WIDTH(WIDTH)) u_load_dec (
        .bin_i  (CNT_ZERO),
        .gray_o (unused_gray_s),
        .gray_i (LoadVal),
        .bin_o  (load_bin_s)
    );

    gray_conv #(.WIDTH(WIDTH)) u_out_enc (
        .bin_i  (bcnt_d),
        .gray_o (gray_d),
        .gray_i (CNT_ZERO),
        .bin_o  (unused_bin_s)
    );

    // Next count: load beats enable; boundary steps either wrap or hold and raise an event.
    always_comb begin
        bcnt_d    = bcnt_q;
        ovf_evt_s = 1'b0;
        unf_evt_s = 1'b0;
        if (Load) begin
            bcnt_d = load_bin_s;
        end else if (En) begin
            if (Up) begin
                if (bcnt_q == CNT_MAX) begin
                    ovf_evt_s = 1'b1;
                    bcnt_d    = WRAP ? CNT_ZERO : CNT_MAX;
                end else begin
                    bcnt_d = bcnt_q + CNT_ONE;
                end
            end else begin
                if (bcnt_q == CNT_ZERO) begin
                    unf_evt_s = 1'b1;
                    bcnt_d    = WRAP ? CNT_MAX : CNT_ZERO;
                end else begin
                    bcnt_d = bcnt_q - CNT_ONE;
                end
            end
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // Flag next state: a new event always wins over a same-edge clear.
    always_comb begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (STICKY) begin
            ovf_d = ovf_evt_s | (ovf_q & ~ClrFlags);
            unf_d = unf_evt_s | (unf_q & ~ClrFlags);
        end else begin
            ovf_d = ovf_evt_s;
            unf_d = unf_evt_s;
        end
    end

    // Count, Gray image and flag registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bcnt_q <= CNT_ZERO;
            gray_q <= CNT_ZERO;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign Output    = gray_q;
    assign Binary    = bcnt_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: three instances cover wrap/sticky,
// saturate (WIDTH=4) and pulse-flag configurations.
module tb_gray_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_en, a_up, a_load, a_clr;
    logic [2:0] a_lv, a_out, a_bin;
    logic       a_ovf, a_unf;
    logic       b_en, b_up, b_load, b_clr;
    logic [3:0] b_lv, b_out, b_bin;
    logic       b_ovf, b_unf;
    logic       c_en, c_up, c_load, c_clr;
    logic [2:0] c_lv, c_out, c_bin;
    logic       c_ovf, c_unf;

    int checks = 0;
    int errors = 0;

    gray_counter_param #(.WIDTH(3), .WRAP(1'b1), .STICKY(1'b1)) u_dut_a (
        .Clk(clk), .Reset(rst_n), .En(a_en), .Up(a_up), .Load(a_load),
        .LoadVal(a_lv), .ClrFlags(a_clr), .Output(a_out), .Binary(a_bin),
        .Overflow(a_ovf), .Underflow(a_unf)
    );

    gray_counter_param #(.WIDTH(4), .WRAP(1'b0), .STICKY(1'b1)) u_dut_b (
        .Clk(clk), .Reset(rst_n), .En(b_en), .Up(b_up), .Load(b_load),
        .LoadVal(b_lv), .ClrFlags(b_clr), .Output(b_out), .Binary(b_bin),
        .Overflow(b_ovf), .Underflow(b_unf)
    );

    gray_counter_param #(.WIDTH(3), .WRAP(1'b1), .STICKY(1'b0)) u_dut_c (
        .Clk(clk), .Reset(rst_n), .En(c_en), .Up(c_up), .Load(c_load),
        .LoadVal(c_lv), .ClrFlags(c_clr), .Output(c_out), .Binary(c_bin),
        .Overflow(c_ovf), .Underflow(c_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {a_en, a_up, a_load, a_clr, a_lv} = '0;
        {b_en, b_up, b_load, b_clr, b_lv} = '0;
        {c_en, c_up, c_load, c_clr, c_lv} = '0;
        #2;
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== 8'h00) begin
            errors++; $display("FAIL reset_a: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, 8'h00);
        end
        checks++;
        if ({b_out, b_bin, b_ovf, b_unf} !== 10'h000) begin
            errors++; $display("FAIL reset_b: got %b expected %b", {b_out, b_bin, b_ovf, b_unf}, 10'h000);
        end
        checks++;
        if ({c_out, c_bin, c_ovf, c_unf} !== 8'h00) begin
            errors++; $display("FAIL reset_c: got %b expected %b", {c_out, c_bin, c_ovf, c_unf}, 8'h00);
        end
        a_en = 1'b1; a_up = 1'b1;
        tick();
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== 8'h00) begin
            errors++; $display("FAIL reset_hold: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, 8'h00);
        end
    endtask

    task automatic test_count_wrap();
        logic [2:0] gseq [9];
        logic [2:0] prev;
        logic [2:0] exp_bin;
        logic       exp_ovf;
        gseq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
        prev = a_out;
        rst_n = 1'b1; a_en = 1'b1; a_up = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_bin = 3'((i + 1) % 8);
            exp_ovf = (i >= 7);
            checks++;
            if ({a_out, a_bin, a_ovf, a_unf} !== {gseq[i], exp_bin, exp_ovf, 1'b0}) begin
                errors++;
                $display("FAIL count_wrap step %0d: got %b expected %b", i + 1,
                         {a_out, a_bin, a_ovf, a_unf}, {gseq[i], exp_bin, exp_ovf, 1'b0});
            end
            checks++;
            if ($countones(prev ^ a_out) != 1) begin
                errors++; $display("FAIL gray_one_bit step %0d: got %b -> %b expected one bit change", i + 1, prev, a_out);
            end
            prev = a_out;
        end
        a_en = 1'b0;
    endtask

    task automatic test_down_underflow();
        a_load = 1'b1; a_lv = 3'b000; a_clr = 1'b1;
        tick();
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== {3'b000, 3'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load_zero_clr: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, 8'h00);
        end
        a_load = 1'b0; a_clr = 1'b0; a_en = 1'b1; a_up = 1'b0;
        tick();
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== {3'b100, 3'd7, 1'b0, 1'b1}) begin
            errors++; $display("FAIL underflow_wrap: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, {3'b100, 3'd7, 1'b0, 1'b1});
        end
        tick();
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== {3'b101, 3'd6, 1'b0, 1'b1}) begin
            errors++; $display("FAIL down_after_wrap: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, {3'b101, 3'd6, 1'b0, 1'b1});
        end
        a_en = 1'b0;
    endtask

    task automatic test_saturate();
        b_load = 1'b1; b_lv = 4'b1000;
        tick();
        checks++;
        if ({b_out, b_bin, b_ovf, b_unf} !== {4'b1000, 4'd15, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sat_load: got %b expected %b", {b_out, b_bin, b_ovf, b_unf}, {4'b1000, 4'd15, 1'b0, 1'b0});
        end
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({b_out, b_bin, b_ovf, b_unf} !== {4'b1000, 4'd15, 1'b1, 1'b0}) begin
                errors++; $display("FAIL sat_hold_max %0d: got %b expected %b", i, {b_out, b_bin, b_ovf, b_unf}, {4'b1000, 4'd15, 1'b1, 1'b0});
            end
        end
        b_up = 1'b0;
        tick();
        checks++;
        if ({b_out, b_bin, b_ovf, b_unf} !== {4'b1001, 4'd14, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sat_down: got %b expected %b", {b_out, b_bin, b_ovf, b_unf}, {4'b1001, 4'd14, 1'b1, 1'b0});
        end
        b_en = 1'b0; b_load = 1'b1; b_lv = 4'b0000; b_clr = 1'b1;
        tick();
        b_load = 1'b0; b_clr = 1'b0; b_en = 1'b1; b_up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({b_out, b_bin, b_ovf, b_unf} !== {4'b0000, 4'd0, 1'b0, 1'b1}) begin
                errors++; $display("FAIL sat_hold_zero %0d: got %b expected %b", i, {b_out, b_bin, b_ovf, b_unf}, {4'b0000, 4'd0, 1'b0, 1'b1});
            end
        end
        b_en = 1'b0;
    endtask

    task automatic test_flag_race();
        a_load = 1'b1; a_lv = 3'b100; a_clr = 1'b1;
        tick();
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== {3'b100, 3'd7, 1'b0, 1'b0}) begin
            errors++; $display("FAIL clr_alone: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, {3'b100, 3'd7, 1'b0, 1'b0});
        end
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b1; a_clr = 1'b1;
        tick();
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== {3'b000, 3'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL set_wins: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, {3'b000, 3'd0, 1'b1, 1'b0});
        end
        a_en = 1'b0;
        tick();
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== {3'b000, 3'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL clr_after_set: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, 8'h00);
        end
        a_clr = 1'b0;
        c_load = 1'b1; c_lv = 3'b100;
        tick();
        c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
        tick();
        checks++;
        if ({c_out, c_bin, c_ovf, c_unf} !== {3'b000, 3'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL pulse_ovf_set: got %b expected %b", {c_out, c_bin, c_ovf, c_unf}, {3'b000, 3'd0, 1'b1, 1'b0});
        end
        c_en = 1'b0;
        tick();
        checks++;
        if ({c_out, c_bin, c_ovf, c_unf} !== {3'b000, 3'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL pulse_ovf_drop: got %b expected %b", {c_out, c_bin, c_ovf, c_unf}, 8'h00);
        end
        c_en = 1'b1; c_up = 1'b0; c_clr = 1'b1;
        tick();
        checks++;
        if ({c_out, c_bin, c_ovf, c_unf} !== {3'b100, 3'd7, 1'b0, 1'b1}) begin
            errors++; $display("FAIL pulse_unf_clr_ignored: got %b expected %b", {c_out, c_bin, c_ovf, c_unf}, {3'b100, 3'd7, 1'b0, 1'b1});
        end
        tick();
        checks++;
        if ({c_out, c_bin, c_ovf, c_unf} !== {3'b101, 3'd6, 1'b0, 1'b0}) begin
            errors++; $display("FAIL pulse_unf_drop: got %b expected %b", {c_out, c_bin, c_ovf, c_unf}, {3'b101, 3'd6, 1'b0, 1'b0});
        end
        c_en = 1'b0; c_clr = 1'b0;
    endtask

    task automatic test_load_priority();
        a_load = 1'b1; a_en = 1'b1; a_up = 1'b1; a_lv = 3'b110;
        tick();
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== {3'b110, 3'd4, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load_priority: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, {3'b110, 3'd4, 1'b0, 1'b0});
        end
        a_load = 1'b0; a_en = 1'b0;
    endtask

    task automatic test_direction();
        a_en = 1'b1; a_up = 1'b1;
        tick();
        checks++;
        if ({a_out, a_bin} !== {3'b111, 3'd5}) begin
            errors++; $display("FAIL dir_up: got %b expected %b", {a_out, a_bin}, {3'b111, 3'd5});
        end
        a_up = 1'b0;
        tick();
        checks++;
        if ({a_out, a_bin} !== {3'b110, 3'd4}) begin
            errors++; $display("FAIL dir_down: got %b expected %b", {a_out, a_bin}, {3'b110, 3'd4});
        end
        a_up = 1'b1;
        tick();
        checks++;
        if ({a_out, a_bin} !== {3'b111, 3'd5}) begin
            errors++; $display("FAIL dir_up_again: got %b expected %b", {a_out, a_bin}, {3'b111, 3'd5});
        end
    endtask

    task automatic test_async_reset();
        a_en = 1'b1; a_up = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== 8'h00) begin
            errors++; $display("FAIL async_reset_a: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, 8'h00);
        end
        checks++;
        if ({b_out, b_bin, b_ovf, b_unf} !== 10'h000) begin
            errors++; $display("FAIL async_reset_b: got %b expected %b", {b_out, b_bin, b_ovf, b_unf}, 10'h000);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({a_out, a_bin, a_ovf, a_unf} !== {3'b001, 3'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_release: got %b expected %b", {a_out, a_bin, a_ovf, a_unf}, {3'b001, 3'd1, 1'b0, 1'b0});
        end
        a_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_down_underflow();
        test_saturate();
        test_flag_race();
        test_load_priority();
        test_direction();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
